// File: rtl/ps2_keyboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_keyboard                                                  |
// | Purpose  : PS/2 scan-code-set-2 receiver with make/break/extended        |
// |            tracking, Shift/CapsLock state, ASCII translation, key class  |
// |            and six active-low 7-segment debug digits.                    |
// | Option   : define PS2_PARITY_CHECK_EN to drop frames with bad odd parity |
// |            or a stop bit that is not 1.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ps2_keyboard (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [7:0] data,
  output logic [7:0] ascll,
  output logic [2:0] MODEL,
  output logic       ready
);

  // PS/2 lines are open-collector inputs here; this block never drives them.
  logic [2:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;
  logic        ps2_fall;
  logic [3:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic [15:0] wdog_q;
  logic        frame_vld_q;
  logic        frame_ok;

  // Decoder state (_q) and its next-state (_d)
  logic [7:0] data_q, data_d, ascll_q, ascll_d, mcnt_q, mcnt_d;
  logic [2:0] model_q, model_d;
  logic       ready_q, ready_d, ext_q, ext_d, brk_q, brk_d;
  logic       shl_q, shl_d, shr_q, shr_d, caps_q, caps_d, caps_held_q, caps_held_d;
  logic       disp_q, disp_d;
  logic [8:0] last_q, last_d;
  logic [16:0] lut;
  logic        shift_held;

  // Set-2 code -> {is_letter, unshifted ASCII, shifted ASCII}; zero = unmapped
  function automatic logic [16:0] ascii_lut(input logic [7:0] code);
    logic [16:0] r;
    r = '0;
    case (code)
      8'h1C: r = {1'b1, 8'h61, 8'h41};  8'h32: r = {1'b1, 8'h62, 8'h42};
      8'h21: r = {1'b1, 8'h63, 8'h43};  8'h23: r = {1'b1, 8'h64, 8'h44};
      8'h24: r = {1'b1, 8'h65, 8'h45};  8'h2B: r = {1'b1, 8'h66, 8'h46};
      8'h34: r = {1'b1, 8'h67, 8'h47};  8'h33: r = {1'b1, 8'h68, 8'h48};
      8'h43: r = {1'b1, 8'h69, 8'h49};  8'h3B: r = {1'b1, 8'h6A, 8'h4A};
      8'h42: r = {1'b1, 8'h6B, 8'h4B};  8'h4B: r = {1'b1, 8'h6C, 8'h4C};
      8'h3A: r = {1'b1, 8'h6D, 8'h4D};  8'h31: r = {1'b1, 8'h6E, 8'h4E};
      8'h44: r = {1'b1, 8'h6F, 8'h4F};  8'h4D: r = {1'b1, 8'h70, 8'h50};
      8'h15: r = {1'b1, 8'h71, 8'h51};  8'h2D: r = {1'b1, 8'h72, 8'h52};
      8'h1B: r = {1'b1, 8'h73, 8'h53};  8'h2C: r = {1'b1, 8'h74, 8'h54};
      8'h3C: r = {1'b1, 8'h75, 8'h55};  8'h2A: r = {1'b1, 8'h76, 8'h56};
      8'h1D: r = {1'b1, 8'h77, 8'h57};  8'h22: r = {1'b1, 8'h78, 8'h58};
      8'h35: r = {1'b1, 8'h79, 8'h59};  8'h1A: r = {1'b1, 8'h7A, 8'h5A};
      8'h45: r = {1'b0, 8'h30, 8'h29};  8'h16: r = {1'b0, 8'h31, 8'h21};
      8'h1E: r = {1'b0, 8'h32, 8'h40};  8'h26: r = {1'b0, 8'h33, 8'h23};
      8'h25: r = {1'b0, 8'h34, 8'h24};  8'h2E: r = {1'b0, 8'h35, 8'h25};
      8'h36: r = {1'b0, 8'h36, 8'h5E};  8'h3D: r = {1'b0, 8'h37, 8'h26};
      8'h3E: r = {1'b0, 8'h38, 8'h2A};  8'h46: r = {1'b0, 8'h39, 8'h28};
      8'h4E: r = {1'b0, 8'h2D, 8'h5F};  8'h55: r = {1'b0, 8'h3D, 8'h2B};
      8'h54: r = {1'b0, 8'h5B, 8'h7B};  8'h5B: r = {1'b0, 8'h5D, 8'h7D};
      8'h4C: r = {1'b0, 8'h3B, 8'h3A};  8'h52: r = {1'b0, 8'h27, 8'h22};
      8'h41: r = {1'b0, 8'h2C, 8'h3C};  8'h49: r = {1'b0, 8'h2E, 8'h3E};
      8'h4A: r = {1'b0, 8'h2F, 8'h3F};  8'h5D: r = {1'b0, 8'h5C, 8'h7C};
      8'h0E: r = {1'b0, 8'h60, 8'h7E};  8'h29: r = {1'b0, 8'h20, 8'h20};
      8'h5A: r = {1'b0, 8'h0D, 8'h0D};  8'h66: r = {1'b0, 8'h08, 8'h08};
      8'h0D: r = {1'b0, 8'h09, 8'h09};  8'h76: r = {1'b0, 8'h1B, 8'h1B};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Hex nibble -> active-low segments {g..a}
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Two-flop synchronizers; the third clock stage remembers the previous level
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
    end
  end

  assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;

  // Capture the parity bit (bit index 9) for the acceptance test on the stop bit
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N)                            par_q <= 1'b0;
    else if (ps2_fall && bitcnt_q == 4'd9) par_q <= dat_sync_q[1];
  end

  assign frame_ok = (^{shift_q, par_q}) & dat_sync_q[1];
`else
  assign frame_ok = 1'b1;
`endif

  // Bit counter, data shifter and stalled-frame watchdog
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      bitcnt_q    <= '0;
      shift_q     <= '0;
      wdog_q      <= '0;
      frame_vld_q <= 1'b0;
    end else begin
      frame_vld_q <= 1'b0;
      if (ps2_fall) begin
        wdog_q <= '0;
        if (bitcnt_q == 4'd10) begin
          bitcnt_q    <= '0;
          frame_vld_q <= frame_ok;
        end else begin
          bitcnt_q <= bitcnt_q + 4'd1;
          if (bitcnt_q >= 4'd1 && bitcnt_q <= 4'd8)
            shift_q <= {dat_sync_q[1], shift_q[7:1]};
        end
      end else if (bitcnt_q != 4'd0) begin
        if (wdog_q == 16'hFFFF) begin
          bitcnt_q <= '0;
          wdog_q   <= '0;
        end else begin
          wdog_q <= wdog_q + 16'd1;
        end
      end
    end
  end

  assign lut        = ascii_lut(shift_q);
  assign shift_held = shl_q | shr_q;

  // Byte decoder: prefixes set flags, any other byte consumes them
  always_comb begin
    data_d = data_q;   ascll_d = ascll_q;   model_d = model_q;  ready_d = 1'b0;
    ext_d  = ext_q;    brk_d   = brk_q;     shl_d   = shl_q;    shr_d   = shr_q;
    caps_d = caps_q;   caps_held_d = caps_held_q;  last_d = last_q;
    mcnt_d = mcnt_q;   disp_d  = disp_q;
    if (frame_vld_q) begin
      data_d = shift_q;
      disp_d = 1'b1;
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          if (!ext_q) begin
            if (shift_q == 8'h12) shl_d = 1'b0;
            if (shift_q == 8'h59) shr_d = 1'b0;
            if (shift_q == 8'h58) caps_held_d = 1'b0;
          end
          if ({ext_q, shift_q} == last_q) model_d = 3'd0;
        end else begin
          ready_d = 1'b1;
          mcnt_d  = mcnt_q + 8'd1;
          last_d  = {ext_q, shift_q};
          if (ext_q) begin
            model_d = 3'd5;
            ascll_d = 8'h00;
          end else if (shift_q == 8'h12 || shift_q == 8'h59 ||
                       shift_q == 8'h14 || shift_q == 8'h58) begin
            model_d = 3'd2;
            ascll_d = 8'h00;
            if (shift_q == 8'h12) shl_d = 1'b1;
            if (shift_q == 8'h59) shr_d = 1'b1;
            // Typematic repeats of CapsLock arrive while held and must not re-toggle
            if (shift_q == 8'h58 && !caps_held_q) begin
              caps_d      = ~caps_q;
              caps_held_d = 1'b1;
            end
          end else if (lut[15:8] == 8'h00) begin
            model_d = 3'd1;
            ascll_d = 8'h00;
          end else begin
            if (lut[16]) ascll_d = (shift_held ^ caps_q) ? lut[7:0] : lut[15:8];
            else         ascll_d = shift_held ? lut[7:0] : lut[15:8];
            model_d = shift_held ? 3'd3 : (caps_q ? 3'd4 : 3'd1);
          end
        end
      end
    end
  end

  // Decoder state registers
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= '0;  ascll_q <= '0;  model_q <= '0;  ready_q <= 1'b0;
      ext_q  <= 1'b0; brk_q  <= 1'b0; shl_q  <= 1'b0; shr_q  <= 1'b0;
      caps_q <= 1'b0; caps_held_q <= 1'b0; last_q <= '0; mcnt_q <= '0;
      disp_q <= 1'b0;
    end else begin
      data_q <= data_d;  ascll_q <= ascll_d;  model_q <= model_d;  ready_q <= ready_d;
      ext_q  <= ext_d;   brk_q   <= brk_d;    shl_q   <= shl_d;    shr_q   <= shr_d;
      caps_q <= caps_d;  caps_held_q <= caps_held_d;  last_q <= last_d;
      mcnt_q <= mcnt_d;  disp_q  <= disp_d;
    end
  end

  assign data  = data_q;
  assign ascll = ascll_q;
  assign MODEL = model_q;
  assign ready = ready_q;

  // Digits stay blank until the first byte has been accepted after reset
  assign HEX0 = disp_q ? seg7(data_q[3:0])  : 7'h7F;
  assign HEX1 = disp_q ? seg7(data_q[7:4])  : 7'h7F;
  assign HEX2 = disp_q ? seg7(ascll_q[3:0]) : 7'h7F;
  assign HEX3 = disp_q ? seg7(ascll_q[7:4]) : 7'h7F;
  assign HEX4 = disp_q ? seg7(mcnt_q[3:0])  : 7'h7F;
  assign HEX5 = disp_q ? seg7(mcnt_q[7:4])  : 7'h7F;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_ps2_keyboard                                               |
// | Purpose  : Scoreboard bench for ps2_keyboard: frames are driven on the   |
// |            raw PS/2 lines, expected make results are queued, and a       |
// |            monitor compares them whenever ready pulses.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ps2_keyboard;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c  = 1'b1;
  logic       ps2d  = 1'b1;
  wire        ps2_clk_w;
  wire        ps2_dat_w;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [7:0] data, ascll;
  logic [2:0] model;
  logic       ready;

  assign ps2_clk_w = ps2c;
  assign ps2_dat_w = ps2d;

  ps2_keyboard dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .PS2_CLK  (ps2_clk_w),
    .PS2_DAT  (ps2_dat_w),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5),
    .data     (data),
    .ascll    (ascll),
    .MODEL    (model),
    .ready    (ready)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
    logic [2:0] m;
    int         edge_n;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_rdy = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of an 11-bit frame; a make code also queues its result
  task automatic send(input logic [7:0] b, input int nbits, input bit bad_par,
                      input bit is_make, input logic [7:0] ea, input logic [2:0] em);
    logic [10:0] f;
    exp_t x;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2d = f[i];
      wait_n(4);
      ps2c = 1'b0;
      if (i == 10 && is_make) begin
        x.d = b; x.a = ea; x.m = em; x.edge_n = cyc + 1;
        q.push_back(x);
      end
      wait_n(8);
      ps2c = 1'b1;
      wait_n(3);
    end
    wait_n(6);
  endtask

  task automatic make(input logic [7:0] b, input logic [7:0] ea, input logic [2:0] em);
    send(b, 11, 1'b0, 1'b1, ea, em);
  endtask

  task automatic plain(input logic [7:0] b);
    send(b, 11, 1'b0, 1'b0, 8'h00, 3'd0);
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (ready) begin
      chk("ready_width_prev", prev_rdy, 0);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got pulse with data 0x%0h, expected none", data);
      end else begin
        e = q.pop_front();
        chk("data", data, e.d);
        chk("ascll", ascll, e.a);
        chk("MODEL", model, e.m);
        chk("latency", cyc - e.edge_n, 3);
      end
    end
    prev_rdy = ready;
  end

  initial begin
    // Reset state
    wait_n(3);
    chk("rst_data", data, 0);  chk("rst_ascll", ascll, 0);
    chk("rst_model", model, 0); chk("rst_ready", ready, 0);
    chk("rst_hex0", hex0, 7'h7F); chk("rst_hex1", hex1, 7'h7F);
    chk("rst_hex2", hex2, 7'h7F); chk("rst_hex3", hex3, 7'h7F);
    chk("rst_hex4", hex4, 7'h7F); chk("rst_hex5", hex5, 7'h7F);
    @(negedge clk) rst_n = 1'b1;
    wait_n(5);

    // Plain letter
    make(8'h1C, 8'h61, 3'd1);
    chk("hex1_1C", hex1, 7'h79); chk("hex0_1C", hex0, 7'h46);
    chk("hex3_61", hex3, 7'h02); chk("hex2_61", hex2, 7'h79);
    chk("hex5_cnt1", hex5, 7'h40); chk("hex4_cnt1", hex4, 7'h79);

    // Shift + letter, then breaks
    make(8'h12, 8'h00, 3'd2);
    make(8'h1C, 8'h41, 3'd3);
    plain(8'hF0); plain(8'h1C);
    chk("brk1C_model", model, 0); chk("brk1C_ascll", ascll, 8'h41);
    plain(8'hF0); plain(8'h12);
    chk("brk12_model", model, 0); chk("brk12_data", data, 8'h12);

    // CapsLock on, letter, shift cancels caps, typematic caps toggles once
    make(8'h58, 8'h00, 3'd2);
    plain(8'hF0); plain(8'h58);
    make(8'h1C, 8'h41, 3'd4);
    make(8'h12, 8'h00, 3'd2);
    make(8'h1C, 8'h61, 3'd3);
    plain(8'hF0); plain(8'h12);
    make(8'h58, 8'h00, 3'd2);
    make(8'h58, 8'h00, 3'd2);
    make(8'h1C, 8'h61, 3'd1);
    plain(8'hF0); plain(8'h58);

    // Extended make and break
    plain(8'hE0);
    make(8'h75, 8'h00, 3'd5);
    plain(8'hE0); plain(8'hF0); plain(8'h75);
    chk("extbrk_model", model, 0); chk("extbrk_data", data, 8'h75);

    // Wrong parity
`ifdef PS2_PARITY_CHECK_EN
    send(8'h1C, 11, 1'b1, 1'b0, 8'h00, 3'd0);
    chk("badpar_data", data, 8'h75);
`else
    send(8'h1C, 11, 1'b1, 1'b1, 8'h61, 3'd1);
    chk("badpar_data", data, 8'h1C);
`endif

    // Stalled partial frame is discarded by the watchdog
    send(8'hA5, 5, 1'b0, 1'b0, 8'h00, 3'd0);
    wait_n(66000);
    make(8'h29, 8'h20, 3'd1);

    // Shifted digit and symbol, Enter
    make(8'h12, 8'h00, 3'd2);
    make(8'h16, 8'h21, 3'd3);
    plain(8'hF0); plain(8'h12);
    make(8'h4E, 8'h2D, 3'd1);
    make(8'h5A, 8'h0D, 3'd1);
    chk("hex3_0D", hex3, 7'h40); chk("hex2_0D", hex2, 7'h21);
    chk("hex5_cnt", hex5, 7'h79);
`ifdef PS2_PARITY_CHECK_EN
    chk("hex4_cnt", hex4, 7'h40);
`else
    chk("hex4_cnt", hex4, 7'h79);
`endif

    // Reset in the middle of a frame
    send(8'h33, 4, 1'b0, 1'b0, 8'h00, 3'd0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_data", data, 0); chk("midrst_ascll", ascll, 0);
    chk("midrst_model", model, 0); chk("midrst_hex0", hex0, 7'h7F);
    chk("midrst_hex5", hex5, 7'h7F);
    wait_n(4);
    @(negedge clk) rst_n = 1'b1;
    wait_n(4);
    make(8'h1C, 8'h61, 3'd1);
    chk("postrst_hex5", hex5, 7'h40); chk("postrst_hex4", hex4, 7'h79);

    wait_n(10);
    chk("pending_expected", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver and decoder for the FPGA console's I/O subsystem. Samples the keyboard's PS2_CLK/PS2_DAT lines, assembles scan-code-set-2 frames, and tracks make/break/extended prefixes plus Shift/CapsLock state. Produces the raw scan code, its ASCII translation, a key-class code (MODEL) and a one-cycle `ready` strobe. It also drives six active-low 7-segment digits for on-board debug.

## Interface
- No parameters.
- CLOCK_50  in  1  system clock, 50 MHz
- RST_N  in  1  asynchronous active-low reset
- PS2_CLK  inout  1  keyboard clock; never driven (constant high-Z), sampled only
- PS2_DAT  inout  1  keyboard data; never driven (constant high-Z), sampled only
- HEX0..HEX5  out  7 each  active-low segments {g..a}
- data  out  8  last valid received byte (raw scan code)
- ascll  out  8  ASCII of last make code; 0 if unmapped
- MODEL  out  3  class of last event (see Operation)
- ready  out  1  one-cycle strobe per decoded make code

## Operation
- PS2_CLK/PS2_DAT pass through 2-FF synchronizers; falling edge = synced clk 1→0 across one CLOCK_50 cycle.
- Frame: 11 bits sampled on falling edges: start(0), 8 data bits LSB first, odd parity, stop(1).
- On the 11th bit, the byte is valid; `data` is updated.
- Decoder:
  - E0 sets ext flag.
  - F0 sets brk flag.
  - Any other byte consumes both flags.
- Break of 12/59 clears the corresponding Shift-held flag.
- Break of the last pressed key sets MODEL=0.
- Break codes never pulse `ready` and never change `ascll`.
- Make codes pulse `ready`, update `ascll` and `MODEL`.
- MODEL values:
  - 0: no key held / released
  - 1: printable key, no modifier
  - 2: modifier make (12, 59 Shift; 14 Ctrl; 58 Caps); ascll=0
  - 3: printable key with Shift held
  - 4: printable key with CapsLock on and Shift not held
  - 5: extended (E0) make; ascll=0
  - 6, 7: unused
- Unmapped non-modifier make: MODEL=1, ascll=0.
- CapsLock toggles only on the first make of 58; typematic repeats while held are ignored until its break.
- ASCII map:
  - Letters: lowercase; uppercase when Shift XOR Caps.
  - Digits 0-9, with US Shift symbols (`!@#$%^&*()`), also `-=[];',./\`` and their shifted forms.
  - Space 29→0x20, Enter 5A→0x0D, Backspace 66→0x08, Tab 0D→0x09, Esc 76→0x1B.
  - Caps affects letters only.
- HEX display:
  - HEX1:HEX0 = `data` in hex.
  - HEX3:HEX2 = `ascll` in hex.
  - HEX5:HEX4 = 8-bit make-code count, wraps 0xFF→0x00.
- Watchdog: if a frame is in progress and no falling edge occurs for 65536 CLOCK_50 cycles, the bit counter clears and the partial frame is discarded.

## Timing
- Reset (async assert, sync release):
  - data=0, ascll=0, MODEL=0, ready=0.
  - Shift/Caps/ext/brk flags and counter = 0.
  - All HEX = 7'h7F (blank).
- Reset mid-frame discards the partial frame.
- Latency: the falling edge of the stop bit, as seen on raw PS2_CLK, is sampled at CLOCK_50 edge N. `data` updates at edge N+3; `ascll`/`MODEL` update and `ready`=1 during cycle N+3 → N+4 only.
- `ready` is exactly one cycle wide, with at most one pulse per received byte.
- Typematic repeat: each repeated make gives a new pulse.
- HEX outputs are combinational from their registers; they lag data by 0 cycles.
- A byte arriving while a prefix flag is set is processed with that flag; back-to-back frames need no gap.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - Frames with wrong odd parity or stop bit ≠ 1 are silently dropped.
  - On a dropped frame: no `data` update, no `ready`, flags unchanged.
- Undefined: parity and stop bits are ignored and every 11-bit frame is accepted.

## Test plan
- Reset, then send frame 1C (parity 0) → data=0x1C, ascll=0x61, MODEL=1, one `ready` pulse exactly 3 cycles after the stop-bit edge, HEX1:HEX0="1C", HEX5:HEX4="01".
- Send 12, 1C, F0 1C, F0 12 → first 12 gives MODEL=2, ascll=0; then 0x41 with MODEL=3; the breaks give MODEL=0 with no extra pulses (2 pulses total).
- Send 58, F0 58, 1C → Caps on, ascll=0x41, MODEL=4. Then 12, 1C → ascll=0x61, MODEL=3. Repeat 58, 58 without break → Caps toggled once.
- Send E0 75 → MODEL=5, ascll=0, ready pulse. Then E0 F0 75 → MODEL=0, no pulse.
- With `PS2_PARITY_CHECK_EN`, send 1C with parity 1 → no data change, no pulse. Without the macro → accepted.
- Stop PS2_CLK after 5 bits for 70000 cycles, then send 29 → ascll=0x20. Separately, assert RST_N low mid-frame → all outputs reset immediately.
